ex_mem_stage_buf: RTL

Parametrised successor to the plain EX/MEM pipeline register. Carries a packed EX->MEM payload with a valid/ready handshake, synchronous flush, optional 2-entry skid buffer that breaks the combinational ready path, and a saturating back-pressure counter. Sits between the execute stage and the memory stage and accepts any packed control/data bundle.

---
 rtl/ex_mem_stage_buf.sv | 114 +++++++++++
 1 files changed

// File: rtl/ex_mem_stage_buf.sv
// EX->MEM pipeline buffer: valid/ready handshake, synchronous flush,
// optional 2-entry skid buffer and a saturating back-pressure counter.
module ex_mem_stage_buf #(
  parameter int unsigned DATA_W     = 108,
  parameter bit          SKID       = 1'b1,
  parameter bit          CLEAR_DATA = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_q, main_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic                valid_q;
  logic                ready_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                in_fire;
  logic                out_fire;

  // Skid mode uses a registered ready; single-register mode passes ready through.
  assign in_ready_o  = SKID ? ready_q : (!valid_q || out_ready_i);
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = valid_q && out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = main_q;
  assign stall_cnt_o = cnt_q;

  // State, payload and counter registers; valid and ready registered from next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= (state_d != ST_EMPTY);
      ready_q <= (state_d != ST_FULL);
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and payload movement; flush overrides normal operation.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_HALF;
          main_d  = in_data_i;
        end
      end
      ST_HALF: begin
        if (in_fire && out_fire) begin
          main_d = in_data_i;
        end else if (in_fire) begin
          state_d = ST_FULL;
          skid_d  = in_data_i;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
          if (CLEAR_DATA) main_d = '0;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d = ST_HALF;
          main_d  = skid_q;
          if (CLEAR_DATA) skid_d = '0;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = CLEAR_DATA ? '0 : main_q;
      skid_d  = CLEAR_DATA ? '0 : skid_q;
    end
  end

  // Saturating count of cycles where MEM holds off a valid payload.
  always_comb begin
    cnt_d = cnt_q;
    if (valid_q && !out_ready_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

endmodule
